// File: rtl/udp_rx_pkg.sv
// ============================================================================
// Module   : udp_rx_pkg
// Purpose  : Shared state encoding, protocol constants and CRC-32 byte step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package udp_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_ETH_HDR  = 3'd2,
        ST_IP_HDR   = 3'd3,
        ST_UDP_HDR  = 3'd4,
        ST_DATA     = 3'd5,
        ST_TAIL     = 3'd6,
        ST_DROP     = 3'd7
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam logic [15:0] UDP_HDR_LEN   = 16'd8;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    // MSB-first register fed LSB-first per byte, i.e. the reflected-input CRC-32.
    function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/udp_rx_if.sv
// ============================================================================
// Module   : udp_rx_if
// Purpose  : Byte stream in from the GMII capture stage, UDP payload stream out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface udp_rx_if;
    logic [7:0]  rx_databyte;
    logic        rx_databyte_en;
    logic [7:0]  rx_data;
    logic        rx_data_en;
    logic [15:0] rx_byte_num;
    logic [47:0] rx_src_mac;
    logic [31:0] rx_src_ip;
    logic [15:0] rx_src_port;
    logic        rx_done;
    logic        rx_err;

    modport slave (
        input  rx_databyte, rx_databyte_en,
        output rx_data, rx_data_en, rx_byte_num, rx_src_mac, rx_src_ip,
               rx_src_port, rx_done, rx_err
    );

    modport master (
        output rx_databyte, rx_databyte_en,
        input  rx_data, rx_data_en, rx_byte_num, rx_src_mac, rx_src_ip,
               rx_src_port, rx_done, rx_err
    );
endinterface

`default_nettype wire

// File: rtl/udp_rx_crc32.sv
// ============================================================================
// Module   : crc32_d8
// Purpose  : Byte-wide CRC-32 accumulator; built only when UDP_RX_CRC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef UDP_RX_CRC_EN
module crc32_d8
    import udp_rx_pkg::*;
(
    input  wire         clk,
    input  wire         rst,
    input  wire         i_clr,
    input  wire         i_en,
    input  wire  [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_crc <= 32'hFFFF_FFFF;
        end else if (i_en) begin
            r_crc <= crc32_d8_next(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;

endmodule
`endif

`default_nettype wire

// File: rtl/udp_rx.sv
// ============================================================================
// Module   : udp_rx
// Purpose  : GMII-side Ethernet/IPv4/UDP receive filter and payload extractor.
//            Define UDP_RX_CRC_EN to check the FCS before signalling rx_done.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_rx
    import udp_rx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] LOCAL_IP   = 32'hC0_A8_00_64,
    parameter logic [15:0] LOCAL_PORT = 16'd1234
)
(
    input  wire      eth_rxc,
    input  wire      rst,
    udp_rx_if.slave  rx_if
);

    logic [7:0]  w_byte;
    logic        w_en;
    logic [47:0] w_dst_mac;
    logic [31:0] w_field32;
    logic [15:0] w_field16;
    logic        w_crc_ok;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [15:0] r_data_cnt;
    logic        r_en_d;
    logic [39:0] r_shift;
    logic [47:0] r_smac_t;
    logic [31:0] r_sip_t;
    logic [15:0] r_sport_t;
    logic [15:0] r_len_t;

    logic [7:0]  r_rx_data;
    logic        r_rx_data_en;
    logic [15:0] r_rx_byte_num;
    logic [47:0] r_rx_src_mac;
    logic [31:0] r_rx_src_ip;
    logic [15:0] r_rx_src_port;
    logic        r_rx_done;
    logic        r_rx_err;

    assign w_byte    = rx_if.rx_databyte;
    assign w_en      = rx_if.rx_databyte_en;
    // Multi-byte fields are checked on their last byte, joined with the history.
    assign w_dst_mac = {r_shift[39:0], w_byte};
    assign w_field32 = {r_shift[23:0], w_byte};
    assign w_field16 = {r_shift[7:0],  w_byte};

`ifdef UDP_RX_CRC_EN
    logic        w_crc_clr;
    logic        w_crc_en;
    logic [31:0] w_crc;

    assign w_crc_clr = (r_state == ST_PREAMBLE) && w_en && (w_byte == SFD_BYTE);
    assign w_crc_en  = w_en && (r_state inside {ST_ETH_HDR, ST_IP_HDR, ST_UDP_HDR,
                                                ST_DATA, ST_TAIL});

    crc32_d8 u_crc32 (
        .clk    (eth_rxc),
        .rst    (rst),
        .i_clr  (w_crc_clr),
        .i_en   (w_crc_en),
        .i_data (w_byte),
        .o_crc  (w_crc)
    );

    assign w_crc_ok = (w_crc == CRC_RESIDUE);
`else
    assign w_crc_ok = 1'b1;
`endif

    always_ff @(posedge eth_rxc) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_data_cnt    <= '0;
            r_en_d        <= 1'b1;
            r_shift       <= '0;
            r_smac_t      <= '0;
            r_sip_t       <= '0;
            r_sport_t     <= '0;
            r_len_t       <= '0;
            r_rx_data     <= '0;
            r_rx_data_en  <= 1'b0;
            r_rx_byte_num <= '0;
            r_rx_src_mac  <= '0;
            r_rx_src_ip   <= '0;
            r_rx_src_port <= '0;
            r_rx_done     <= 1'b0;
            r_rx_err      <= 1'b0;
        end else begin
            r_en_d       <= w_en;
            r_rx_data_en <= 1'b0;
            r_rx_done    <= 1'b0;
            r_rx_err     <= 1'b0;
            if (w_en) r_shift <= {r_shift[31:0], w_byte};

            case (r_state)
                ST_IDLE: begin
                    if (w_en && !r_en_d && (w_byte == PREAMBLE_BYTE)) begin
                        r_state <= ST_PREAMBLE;
                        r_cnt   <= 6'd1;
                    end
                end

                ST_PREAMBLE: begin
                    if (!w_en) begin
                        r_state <= ST_IDLE;
                    end else if ((w_byte == PREAMBLE_BYTE) && (r_cnt < 6'd7)) begin
                        r_cnt <= r_cnt + 6'd1;
                    end else if ((w_byte == SFD_BYTE) && (r_cnt == 6'd7)) begin
                        r_state <= ST_ETH_HDR;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= ST_DROP;
                    end
                end

                ST_ETH_HDR: begin
                    if (!w_en) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        case (r_cnt)
                            6'd5: if ((w_dst_mac != LOCAL_MAC) && (w_dst_mac != 48'hFFFF_FFFF_FFFF))
                                      r_state <= ST_DROP;
                            6'd11: r_smac_t <= w_dst_mac;
                            6'd13: begin
                                if (w_field16 != ETH_TYPE_IPV4) begin
                                    r_state <= ST_DROP;
                                end else begin
                                    r_state <= ST_IP_HDR;
                                    r_cnt   <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ST_IP_HDR: begin
                    if (!w_en) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        case (r_cnt)
                            6'd0:  if (w_byte != IP_VER_IHL)   r_state <= ST_DROP;
                            6'd9:  if (w_byte != IP_PROTO_UDP) r_state <= ST_DROP;
                            6'd15: r_sip_t <= w_field32;
                            6'd19: begin
                                if (w_field32 != LOCAL_IP) begin
                                    r_state <= ST_DROP;
                                end else begin
                                    r_state <= ST_UDP_HDR;
                                    r_cnt   <= '0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ST_UDP_HDR: begin
                    if (!w_en) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        case (r_cnt)
                            6'd1: r_sport_t <= w_field16;
                            6'd3: if (w_field16 != LOCAL_PORT) r_state <= ST_DROP;
                            6'd5: begin
                                r_len_t <= w_field16;
                                if (w_field16 < UDP_HDR_LEN) r_state <= ST_DROP;
                            end
                            6'd7: begin
                                r_rx_byte_num <= r_len_t - UDP_HDR_LEN;
                                r_rx_src_mac  <= r_smac_t;
                                r_rx_src_ip   <= r_sip_t;
                                r_rx_src_port <= r_sport_t;
                                r_data_cnt    <= '0;
                                r_state       <= (r_len_t == UDP_HDR_LEN) ? ST_TAIL : ST_DATA;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_DATA: begin
                    if (!w_en) begin
                        r_rx_err <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_rx_data    <= w_byte;
                        r_rx_data_en <= 1'b1;
                        r_data_cnt   <= r_data_cnt + 16'd1;
                        if (r_data_cnt == (r_rx_byte_num - 16'd1)) r_state <= ST_TAIL;
                    end
                end

                ST_TAIL: begin
                    // Padding and FCS are swallowed; the verdict comes when en falls.
                    if (!w_en) begin
                        r_rx_done <= w_crc_ok;
                        r_rx_err  <= !w_crc_ok;
                        r_state   <= ST_IDLE;
                    end
                end

                ST_DROP: begin
                    if (!w_en) r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_if.rx_data     = r_rx_data;
    assign rx_if.rx_data_en  = r_rx_data_en;
    assign rx_if.rx_byte_num = r_rx_byte_num;
    assign rx_if.rx_src_mac  = r_rx_src_mac;
    assign rx_if.rx_src_ip   = r_rx_src_ip;
    assign rx_if.rx_src_port = r_rx_src_port;
    assign rx_if.rx_done     = r_rx_done;
    assign rx_if.rx_err      = r_rx_err;

endmodule

`default_nettype wire

// File: tb/tb_udp_rx.sv
// ============================================================================
// Module   : tb_udp_rx
// Purpose  : Self-checking bench for udp_rx with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_udp_rx;

    localparam logic [47:0] L_MAC  = 48'h00_11_22_33_44_55;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] L_IP   = 32'hC0A8_0064;
    localparam logic [15:0] L_PORT = 16'd1234;
    localparam int          HDR_END = 50;
`ifdef UDP_RX_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    typedef struct {
        logic [47:0] dmac;
        logic [47:0] smac;
        logic [15:0] etype;
        logic [7:0]  verihl;
        logic [7:0]  proto;
        logic [31:0] sip;
        logic [31:0] dip;
        logic [15:0] sport;
        logic [15:0] dport;
        logic [15:0] ulen;
        int          npay;
        bit          bad_fcs;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    udp_rx_if rx_if ();

    udp_rx #(
        .LOCAL_MAC  (L_MAC),
        .LOCAL_IP   (L_IP),
        .LOCAL_PORT (L_PORT)
    ) dut (
        .eth_rxc (clk),
        .rst     (rst),
        .rx_if   (rx_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  frame_q[$];
    logic [7:0]  pay[64];
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          n_done, n_err, exp_done, exp_err, pulse_cyc, fall_cyc;
    bit          excl_bad;
    logic [47:0] exp_mac = '0;
    logic [31:0] exp_ip = '0;
    logic [15:0] exp_port = '0;
    logic [15:0] exp_bn = '0;

    always @(negedge clk) begin
        if (rx_if.rx_data_en) got_q.push_back(rx_if.rx_data);
        if (rx_if.rx_done) begin n_done++; pulse_cyc = cyc; end
        if (rx_if.rx_err)  begin n_err++;  pulse_cyc = cyc; end
        if ((rx_if.rx_done && rx_if.rx_err) ||
            ((rx_if.rx_done || rx_if.rx_err) && rx_if.rx_data_en)) excl_bad = 1'b1;
    end

    task automatic clear_obs();
        got_q.delete(); exp_q.delete();
        n_done = 0; n_err = 0; exp_done = 0; exp_err = 0;
        pulse_cyc = -1; excl_bad = 1'b0;
    endtask

    task automatic fill_pay(input int n, input bit ramp);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r = $urandom;
            pay[i] = ramp ? 8'(i + 1) : r[7:0];
        end
    endtask

    function automatic frame_t good_frame(input int npay);
        frame_t f;
        logic [31:0] a, b, c;
        a = $urandom; b = $urandom; c = $urandom;
        f.dmac = L_MAC;        f.smac = {a[15:0], b};
        f.etype = 16'h0800;    f.verihl = 8'h45;  f.proto = 8'd17;
        f.sip = c;             f.dip = L_IP;
        f.sport = a[31:16];    f.dport = L_PORT;
        f.ulen = 16'(npay + 8); f.npay = npay;    f.bad_fcs = 1'b0;
        return f;
    endfunction

    task automatic push_n(input logic [47:0] v, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) frame_q.push_back(v[8*i +: 8]);
    endtask

    task automatic build_frame(input frame_t f);
        logic [31:0] c;
        frame_q.delete();
        repeat (7) frame_q.push_back(8'h55);
        frame_q.push_back(8'hD5);
        push_n(f.dmac, 6); push_n(f.smac, 6); push_n(48'(f.etype), 2);
        frame_q.push_back(f.verihl); frame_q.push_back(8'h00);
        push_n(48'(f.ulen + 16'd20), 2); push_n(48'h0, 2); push_n(48'h4000, 2);
        frame_q.push_back(8'h40); frame_q.push_back(f.proto); push_n(48'h0, 2);
        push_n(48'(f.sip), 4); push_n(48'(f.dip), 4);
        push_n(48'(f.sport), 2); push_n(48'(f.dport), 2); push_n(48'(f.ulen), 2); push_n(48'h0, 2);
        for (int i = 0; i < f.npay; i++) frame_q.push_back(pay[i]);
        while (frame_q.size() - 8 < 60) frame_q.push_back(8'h00);
        // Standard Ethernet FCS: reflected CRC-32, complemented, sent LSB first.
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < frame_q.size(); i++) begin
            c = c ^ 32'(frame_q[i]);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        if (f.bad_fcs) c = c ^ 32'h0000_0010;
        push_n(48'(c[7:0]), 1); push_n(48'(c[15:8]), 1);
        push_n(48'(c[23:16]), 1); push_n(48'(c[31:24]), 1);
    endtask

    task automatic model_frame(input frame_t f, input int trunc);
        bit acc;
        acc = ((f.dmac == L_MAC) || (f.dmac == BCAST)) && (f.etype == 16'h0800) &&
              (f.verihl == 8'h45) && (f.proto == 8'd17) && (f.dip == L_IP) &&
              (f.dport == L_PORT) && (f.ulen >= 16'd8);
        if (acc) begin
            exp_mac = f.smac; exp_ip = f.sip; exp_port = f.sport; exp_bn = f.ulen - 16'd8;
            if (trunc >= 0) begin
                for (int i = 0; i < trunc; i++) exp_q.push_back(pay[i]);
                exp_err++;
            end else begin
                for (int i = 0; i < f.npay; i++) exp_q.push_back(pay[i]);
                if (CRC_EN && f.bad_fcs) exp_err++;
                else                     exp_done++;
            end
        end
    endtask

    task automatic drive_frame(input int n_send, input int gap);
        for (int i = 0; i < n_send; i++) begin
            @(posedge clk); #1;
            rx_if.rx_databyte_en = 1'b1;
            rx_if.rx_databyte    = frame_q[i];
        end
        @(posedge clk); #1;
        rx_if.rx_databyte_en = 1'b0;
        rx_if.rx_databyte    = 8'h00;
        fall_cyc = cyc + 1;
        repeat (gap - 1) @(posedge clk);
    endtask

    task automatic run_frame(input frame_t f, input int trunc, input int gap);
        build_frame(f);
        model_frame(f, trunc);
        drive_frame((trunc >= 0) ? HDR_END + trunc : frame_q.size(), gap);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
    endtask

    function automatic int payload_diff();
        int d;
        d = 0;
        if (got_q.size() != exp_q.size()) return -1;
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    task automatic test_reset();
        frame_t f;
        rst = 1'b1;
        rx_if.rx_databyte_en = 1'b1;
        rx_if.rx_databyte    = 8'h55;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (rx_if.rx_data_en !== 1'b0 || rx_if.rx_done !== 1'b0 || rx_if.rx_err !== 1'b0) begin
            errors++; $display("FAIL reset_strobes got en=%b done=%b err=%b exp 0 0 0",
                               rx_if.rx_data_en, rx_if.rx_done, rx_if.rx_err); end
        checks++; if (rx_if.rx_data !== 8'h00 || rx_if.rx_byte_num !== 16'h0000) begin
            errors++; $display("FAIL reset_data got data=%h num=%h exp 0", rx_if.rx_data, rx_if.rx_byte_num); end
        checks++; if (rx_if.rx_src_mac !== 48'h0 || rx_if.rx_src_ip !== 32'h0 || rx_if.rx_src_port !== 16'h0) begin
            errors++; $display("FAIL reset_src got %h %h %h exp 0", rx_if.rx_src_mac, rx_if.rx_src_ip, rx_if.rx_src_port); end
        // A frame already running when reset releases must be ignored entirely.
        clear_obs();
        fill_pay(8, 1'b0);
        f = good_frame(8);
        build_frame(f);
        rst = 1'b0;
        drive_frame(frame_q.size(), 3);
        settle();
        checks++; if (got_q.size() !== 0) begin
            errors++; $display("FAIL reset_inflight_data got %0d bytes exp 0", got_q.size()); end
        checks++; if (n_done !== 0 || n_err !== 0) begin
            errors++; $display("FAIL reset_inflight_pulses got done=%0d err=%0d exp 0 0", n_done, n_err); end
    endtask

    task automatic test_unicast();
        frame_t f;
        clear_obs();
        fill_pay(4, 1'b1);
        f = good_frame(4);
        run_frame(f, -1, 4);
        settle();
        checks++; if (payload_diff() !== 0) begin
            errors++; $display("FAIL unicast_payload got %0d bytes exp %0d diff=%0d", got_q.size(), exp_q.size(), payload_diff()); end
        checks++; if (n_done !== 1 || n_err !== 0) begin
            errors++; $display("FAIL unicast_pulses got done=%0d err=%0d exp 1 0", n_done, n_err); end
        checks++; if (pulse_cyc !== fall_cyc) begin
            errors++; $display("FAIL unicast_done_timing got cycle %0d exp %0d", pulse_cyc, fall_cyc); end
        checks++; if (rx_if.rx_byte_num !== 16'd4) begin
            errors++; $display("FAIL unicast_byte_num got %0d exp 4", rx_if.rx_byte_num); end
        checks++; if (rx_if.rx_src_mac !== f.smac || rx_if.rx_src_ip !== f.sip || rx_if.rx_src_port !== f.sport) begin
            errors++; $display("FAIL unicast_src got %h %h %h exp %h %h %h", rx_if.rx_src_mac, rx_if.rx_src_ip,
                               rx_if.rx_src_port, f.smac, f.sip, f.sport); end
        checks++; if (excl_bad !== 1'b0) begin
            errors++; $display("FAIL unicast_exclusive got overlap=1 exp 0"); end
    endtask

    task automatic test_broadcast();
        frame_t f;
        clear_obs();
        fill_pay(46, 1'b0);
        f = good_frame(46);
        f.dmac = BCAST;
        run_frame(f, -1, 4);
        settle();
        checks++; if (payload_diff() !== 0 || n_done !== 1) begin
            errors++; $display("FAIL broadcast got %0d bytes done=%0d exp %0d bytes done=1", got_q.size(), n_done, exp_q.size()); end
        checks++; if (rx_if.rx_byte_num !== 16'd46) begin
            errors++; $display("FAIL broadcast_byte_num got %0d exp 46", rx_if.rx_byte_num); end
        clear_obs();
        fill_pay(6, 1'b0);
        f = good_frame(6);
        f.dip = 32'hC0A8_0063;
        run_frame(f, -1, 4);
        settle();
        checks++; if (got_q.size() !== 0 || n_done !== 0 || n_err !== 0) begin
            errors++; $display("FAIL wrong_ip got %0d bytes done=%0d err=%0d exp 0 0 0", got_q.size(), n_done, n_err); end
        checks++; if (rx_if.rx_byte_num !== exp_bn || rx_if.rx_src_ip !== exp_ip) begin
            errors++; $display("FAIL wrong_ip_hold got %0d %h exp %0d %h", rx_if.rx_byte_num, rx_if.rx_src_ip, exp_bn, exp_ip); end
    endtask

    task automatic test_filters();
        frame_t f;
        for (int k = 0; k < 3; k++) begin
            clear_obs();
            fill_pay(5, 1'b0);
            f = good_frame(5);
            if (k == 0) f.etype = 16'h0806;
            if (k == 1) f.proto = 8'd6;
            if (k == 2) f.dport = 16'd1235;
            run_frame(f, -1, 1);
            f = good_frame(5);
            run_frame(f, -1, 4);
            settle();
            checks++; if (payload_diff() !== 0 || n_done !== 1 || n_err !== 0) begin
                errors++; $display("FAIL filter_%0d got %0d bytes done=%0d err=%0d exp %0d bytes done=1 err=0",
                                   k, got_q.size(), n_done, n_err, exp_q.size()); end
            checks++; if (rx_if.rx_src_mac !== f.smac) begin
                errors++; $display("FAIL filter_%0d_src got %h exp %h", k, rx_if.rx_src_mac, f.smac); end
        end
    endtask

    task automatic test_zero_payload();
        frame_t f;
        clear_obs();
        f = good_frame(0);
        run_frame(f, -1, 4);
        settle();
        checks++; if (got_q.size() !== 0 || n_done !== 1 || rx_if.rx_byte_num !== 16'd0) begin
            errors++; $display("FAIL zero_payload got %0d bytes done=%0d num=%0d exp 0 1 0",
                               got_q.size(), n_done, rx_if.rx_byte_num); end
    endtask

    task automatic test_truncation();
        frame_t f;
        clear_obs();
        fill_pay(10, 1'b0);
        f = good_frame(10);
        run_frame(f, 2, 4);
        settle();
        checks++; if (payload_diff() !== 0) begin
            errors++; $display("FAIL trunc_payload got %0d bytes exp %0d", got_q.size(), exp_q.size()); end
        checks++; if (n_err !== 1 || n_done !== 0) begin
            errors++; $display("FAIL trunc_pulses got done=%0d err=%0d exp 0 1", n_done, n_err); end
        checks++; if (pulse_cyc !== fall_cyc) begin
            errors++; $display("FAIL trunc_err_timing got cycle %0d exp %0d", pulse_cyc, fall_cyc); end
    endtask

    task automatic test_crc();
        frame_t f;
        for (int k = 0; k < 2; k++) begin
            clear_obs();
            fill_pay(12, 1'b0);
            f = good_frame(12);
            f.bad_fcs = (k == 1);
            run_frame(f, -1, 4);
            settle();
            checks++; if (payload_diff() !== 0) begin
                errors++; $display("FAIL crc_%0d_payload got %0d bytes exp %0d", k, got_q.size(), exp_q.size()); end
            checks++; if (n_done !== exp_done || n_err !== exp_err) begin
                errors++; $display("FAIL crc_%0d_pulses got done=%0d err=%0d exp %0d %0d", k, n_done, n_err, exp_done, exp_err); end
        end
    endtask

    task automatic test_reset_mid();
        frame_t f;
        clear_obs();
        fill_pay(10, 1'b0);
        f = good_frame(10);
        build_frame(f);
        for (int i = 0; i < frame_q.size(); i++) begin
            @(posedge clk); #1;
            rx_if.rx_databyte_en = 1'b1;
            rx_if.rx_databyte    = frame_q[i];
            rst = (i == HDR_END + 3) || (i == HDR_END + 4);
        end
        @(posedge clk); #1;
        rx_if.rx_databyte_en = 1'b0;
        settle();
        for (int i = 0; i < 3; i++) exp_q.push_back(pay[i]);
        exp_mac = '0; exp_ip = '0; exp_port = '0; exp_bn = '0;
        checks++; if (payload_diff() !== 0) begin
            errors++; $display("FAIL reset_mid_payload got %0d bytes exp 3", got_q.size()); end
        checks++; if (n_done !== 0 || n_err !== 0) begin
            errors++; $display("FAIL reset_mid_pulses got done=%0d err=%0d exp 0 0", n_done, n_err); end
        checks++; if (rx_if.rx_byte_num !== 16'd0 || rx_if.rx_src_mac !== 48'h0) begin
            errors++; $display("FAIL reset_mid_fields got %0d %h exp 0 0", rx_if.rx_byte_num, rx_if.rx_src_mac); end
        clear_obs();
        fill_pay(7, 1'b0);
        f = good_frame(7);
        run_frame(f, -1, 4);
        settle();
        checks++; if (payload_diff() !== 0 || n_done !== 1) begin
            errors++; $display("FAIL reset_mid_next got %0d bytes done=%0d exp 7 1", got_q.size(), n_done); end
    endtask

    task automatic test_random();
        frame_t f;
        int kind, npay, trunc;
        for (int n = 0; n < 24; n++) begin
            clear_obs();
            kind  = $urandom_range(0, 9);
            npay  = (kind == 8) ? $urandom_range(2, 40) : $urandom_range(0, 40);
            trunc = -1;
            fill_pay(npay, 1'b0);
            f = good_frame(npay);
            case (kind)
                1: f.dmac   = L_MAC ^ 48'h0000_0000_0100;
                2: f.etype  = 16'h86DD;
                3: f.verihl = 8'h46;
                4: f.proto  = 8'd6;
                5: f.dip    = L_IP ^ 32'h0000_0001;
                6: f.dport  = L_PORT + 16'd1;
                7: begin f.ulen = 16'($urandom_range(0, 7)); f.npay = 0; end
                8: trunc = $urandom_range(1, npay - 1);
                9: f.bad_fcs = 1'b1;
                default: ;
            endcase
            run_frame(f, trunc, 3);
            settle();
            checks++; if (payload_diff() !== 0) begin
                errors++; $display("FAIL rand%0d_k%0d_payload got %0d bytes exp %0d diff=%0d",
                                   n, kind, got_q.size(), exp_q.size(), payload_diff()); end
            checks++; if (n_done !== exp_done || n_err !== exp_err) begin
                errors++; $display("FAIL rand%0d_k%0d_pulses got done=%0d err=%0d exp %0d %0d",
                                   n, kind, n_done, n_err, exp_done, exp_err); end
            checks++; if (rx_if.rx_byte_num !== exp_bn || rx_if.rx_src_mac !== exp_mac ||
                          rx_if.rx_src_ip !== exp_ip || rx_if.rx_src_port !== exp_port) begin
                errors++; $display("FAIL rand%0d_k%0d_fields got %0d %h %h %h exp %0d %h %h %h", n, kind,
                                   rx_if.rx_byte_num, rx_if.rx_src_mac, rx_if.rx_src_ip, rx_if.rx_src_port,
                                   exp_bn, exp_mac, exp_ip, exp_port); end
            checks++; if (excl_bad !== 1'b0) begin
                errors++; $display("FAIL rand%0d_exclusive got overlap=1 exp 0", n); end
        end
    endtask

    initial begin
        rx_if.rx_databyte    = 8'h00;
        rx_if.rx_databyte_en = 1'b0;
        clear_obs();
        fall_cyc = 0;
        test_reset();
        test_unicast();
        test_broadcast();
        test_filters();
        test_zero_payload();
        test_truncation();
        test_crc();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
